mips_multicycle_core: RTL and testbench

Multicycle MIPS-subset core with one unified memory port and a req/ready handshake, so memory may insert wait states. It is the next generation of our single-cycle datapath top: one shared ALU and an FSM sequence each instruction over several cycles. The core adds a parametrised address width, reset and halt PCs, an illegal-instruction trap, and a retire strobe for benches.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/mips_regfile.sv | 28 ++
 rtl/mips_multicycle_core.sv | 181 ++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct constants, ALU and FSM enums, instruction field widths
package mips_pkg;
    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int IMM_W   = 16;
    localparam int TGT_W   = 26;
    localparam int FUNCT_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] F_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] F_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
        S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT, S_TRAP
    } state_t;
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two async reads, one sync write, $0 hardwired to zero
module mips_regfile
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] raddr1_i,
    input  logic [REG_W-1:0] raddr2_i,
    output logic [31:0]      rdata1_o,
    output logic [31:0]      rdata2_o,
    input  logic             we_i,
    input  logic [REG_W-1:0] waddr_i,
    input  logic [31:0]      wdata_i
);
    logic [31:0] regs_q [32];

    // clear everything on reset; writes to $0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (we_i && waddr_i != '0) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS-subset core with a shared ALU and one req/ready memory port
module mips_multicycle_core
    import mips_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] HALT_PC  = ADDR_W'(1060)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal,
    output logic              retire
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       mdr_q, mdr_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       aluout_q, aluout_d;

    logic [OP_W-1:0]    opcode;
    logic [REG_W-1:0]   rs, rt, rd;
    logic [FUNCT_W-1:0] funct;
    logic [31:0]        sign_imm;
    logic [31:0]        pc32, br_tgt32, jmp_tgt32;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               funct_ok, req_raw;
    alu_op_t            r_op, alu_op;
    logic [31:0]        alu_b, alu_y;
    logic [31:0]        rf_rd1, rf_rd2, rf_wdata;
    logic [REG_W-1:0]   rf_waddr;
    logic               rf_we;
    state_t             dispatch;

    assign opcode    = ir_q[31:26];
    assign rs        = ir_q[25:21];
    assign rt        = ir_q[20:16];
    assign rd        = ir_q[15:11];
    assign funct     = ir_q[FUNCT_W-1:0];
    assign sign_imm  = {{(32-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
    assign pc32      = 32'(pc_q);
    assign pc_plus4  = pc_q + ADDR_W'(4);
    // pc_q already holds PC+4 by the time BRANCH/JUMP run
    assign br_tgt32  = pc32 + {sign_imm[29:0], 2'b00};
    assign jmp_tgt32 = {pc32[31:28], ir_q[TGT_W-1:0], 2'b00};

    assign funct_ok = funct == F_ADD || funct == F_SUB || funct == F_AND || funct == F_OR || funct == F_SLT;
    assign r_op     = funct == F_SUB ? ALU_SUB : funct == F_AND ? ALU_AND :
                      funct == F_OR  ? ALU_OR  : funct == F_SLT ? ALU_SLT : ALU_ADD;
    assign dispatch = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                      opcode == OP_RTYPE ? (funct_ok ? S_EXECUTE : S_TRAP) :
                      opcode == OP_ADDI  ? S_ADDIEX :
                      opcode == OP_BEQ   ? S_BRANCH :
                      opcode == OP_J     ? S_JUMP   : S_TRAP;

    // shared ALU: register operands for R-type and beq compare, immediate otherwise
    always_comb begin
        alu_b  = (state_q == S_EXECUTE || state_q == S_BRANCH) ? b_q : sign_imm;
        alu_op = state_q == S_EXECUTE ? r_op : state_q == S_BRANCH ? ALU_SUB : ALU_ADD;
        alu_y  = alu_op == ALU_SUB ? a_q - alu_b :
                 alu_op == ALU_AND ? a_q & alu_b :
                 alu_op == ALU_OR  ? a_q | alu_b :
                 alu_op == ALU_SLT ? {31'd0, $signed(a_q) < $signed(alu_b)} : a_q + alu_b;
    end

    assign rf_we    = state_q == S_MEMWB || state_q == S_ALUWB || state_q == S_ADDIWB;
    assign rf_waddr = state_q == S_ALUWB ? rd : rt;
    assign rf_wdata = state_q == S_MEMWB ? mdr_q : aluout_q;

    mips_regfile u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .rdata1_o (rf_rd1),
        .rdata2_o (rf_rd2),
        .we_i     (rf_we),
        .waddr_i  (rf_waddr),
        .wdata_i  (rf_wdata)
    );

    // gated by rst_n so the request drops the instant reset is asserted
    assign req_raw   = (state_q == S_FETCH && pc_q != HALT_PC) || state_q == S_MEMRD || state_q == S_MEMWR;
    assign mem_req   = rst_n && req_raw;
    assign mem_we    = mem_req && state_q == S_MEMWR;
    assign mem_addr  = !mem_req ? '0 : state_q == S_FETCH ? pc_q : aluout_q[ADDR_W-1:0];
    assign mem_wdata = mem_we ? b_q : '0;
    assign pc        = pc_q;
    assign halted    = state_q == S_HALT;
    assign illegal   = state_q == S_TRAP;
    assign retire    = state_q == S_MEMWB || state_q == S_ALUWB || state_q == S_ADDIWB ||
                       state_q == S_BRANCH || state_q == S_JUMP || (state_q == S_MEMWR && mem_ready);

    // next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mdr_d    = mdr_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        case (state_q)
            S_FETCH: begin
                if (pc_q == HALT_PC) begin
                    state_d = S_HALT;
                end else if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_plus4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_rd1;
                b_d     = rf_rd2;
                state_d = dispatch;
            end
            S_MEMADR: begin
                aluout_d = alu_y;
                state_d  = alu_y[1:0] != 2'b00 ? S_TRAP : opcode == OP_LW ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = S_MEMWB;
                end
            end
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: begin
                aluout_d = alu_y;
                state_d  = S_ALUWB;
            end
            S_ADDIEX: begin
                aluout_d = alu_y;
                state_d  = S_ADDIWB;
            end
            S_BRANCH: begin
                pc_d    = alu_y == '0 ? br_tgt32[ADDR_W-1:0] : pc_q;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_d    = jmp_tgt32[ADDR_W-1:0];
                state_d = S_FETCH;
            end
            S_MEMWB, S_ALUWB, S_ADDIWB: state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: scoreboard bench driving directed programs through a wait-state memory model
module tb_mips_multicycle_core;
    import mips_pkg::*;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        mem_req, mem_we, mem_ready = 0;
    logic [11:0] mem_addr, pc;
    logic [31:0] mem_wdata, mem_rdata = 0;
    logic        halted, illegal, retire;

    mips_multicycle_core #(.ADDR_W(12), .RESET_PC(12'd0), .HALT_PC(12'd1060)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
        .halted(halted), .illegal(illegal), .retire(retire)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic we; logic [11:0] addr; logic [31:0] data;} acc_t;
    typedef struct packed {logic [7:0] lat; logic [11:0] pc;} ret_t;

    acc_t        exp_acc[$];
    ret_t        exp_ret[$];
    logic [31:0] mem [1024];
    int          n_cmp = 0, n_err = 0, n_ret = 0;
    int          wait_n = 0, wcnt = 0, cyc = 0;
    logic [11:0] wait_addr = 12'hFFF, pc_exp = 0;
    bit          pc_pend = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ei(logic [5:0] op, logic [4:0] s, logic [4:0] t, logic [15:0] imm);
        return {op, s, t, imm};
    endfunction
    function automatic logic [31:0] er(logic [4:0] s, logic [4:0] t, logic [4:0] d, logic [5:0] f);
        return {6'h00, s, t, d, 5'd0, f};
    endfunction
    function automatic logic [31:0] ej(logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    task automatic put(input logic [11:0] a, input logic [31:0] w); mem[a[11:2]] = w; endtask
    task automatic fe(input logic [11:0] a); exp_acc.push_back('{1'b0, a, 32'd0}); endtask
    task automatic rdx(input logic [11:0] a); exp_acc.push_back('{1'b0, a, 32'd0}); endtask
    task automatic wr(input logic [11:0] a, input logic [31:0] d); exp_acc.push_back('{1'b1, a, d}); endtask
    task automatic rt(input logic [7:0] lat, input logic [11:0] p); exp_ret.push_back('{lat, p}); endtask

    // memory model: answers after wait_n stall cycles when the address matches wait_addr
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst_n && mem_req) begin
                if (wcnt >= ((mem_addr == wait_addr) ? wait_n : 0)) begin
                    mem_ready = 1;
                    mem_rdata = mem[mem_addr[11:2]];
                    if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
                    wcnt = 0;
                end else begin
                    mem_ready = 0;
                    mem_rdata = 0;
                    wcnt++;
                end
            end else begin
                mem_ready = 0;
                wcnt = 0;
            end
        end
    end

    // monitor: checks every request cycle against the head access and every retire against the head retire
    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0;
            pc_pend = 0;
        end else begin
            cyc++;
            if (pc_pend) begin
                check("pc_after_retire", 32'(pc), 32'(pc_exp));
                pc_pend = 0;
            end
            if (mem_req) begin
                if (exp_acc.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_req: got addr %h we %b expected no request", mem_addr, mem_we);
                end else begin
                    check("acc_we", 32'(mem_we), 32'(exp_acc[0].we));
                    check("acc_addr", 32'(mem_addr), 32'(exp_acc[0].addr));
                    if (mem_we) check("acc_wdata", mem_wdata, exp_acc[0].data);
                    if (mem_ready) void'(exp_acc.pop_front());
                end
            end
            if (retire) begin
                n_ret++;
                if (exp_ret.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_retire: got retire at pc %h expected none", pc);
                end else begin
                    check("retire_latency", 32'(cyc), 32'(exp_ret[0].lat));
                    pc_exp = exp_ret[0].pc;
                    pc_pend = 1;
                    void'(exp_ret.pop_front());
                end
                cyc = 0;
            end
        end
    end

    task automatic init();
        @(posedge clk);
        #1 rst_n = 0;
        exp_acc.delete();
        exp_ret.delete();
        wait_n = 0;
        wait_addr = 12'hFFF;
        for (int k = 0; k < 1024; k++) mem[k] = 0;
    endtask

    task automatic run(input logic exp_h, input logic exp_i, input int exp_n);
        int  r0;
        bit  done;
        r0 = n_ret;
        done = 0;
        @(posedge clk);
        #1 rst_n = 1;
        for (int k = 0; k < 500 && !done; k++) begin
            @(negedge clk);
            done = halted || illegal;
        end
        check("terminated", 32'(done), 32'd1);
        repeat (4) @(negedge clk);
        check("acc_queue_drained", 32'(exp_acc.size()), 32'd0);
        check("ret_queue_drained", 32'(exp_ret.size()), 32'd0);
        check("halted", 32'(halted), 32'(exp_h));
        check("illegal", 32'(illegal), 32'(exp_i));
        check("retire_count", 32'(n_ret - r0), 32'(exp_n));
        check("req_idle_at_end", 32'(mem_req), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] vals [6];
        logic [4:0]  regs [6];
        // reset values
        init();
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_retire", 32'(retire), 0);

        // addi then store it, then jump to halt
        put(0, ei(OP_ADDI, 0, 1, 16'd5));
        put(4, ei(OP_SW, 0, 1, 16'h100));
        put(8, ej(26'd265));
        fe(0); rt(4, 4);
        fe(4); wr(12'h100, 32'd5); rt(4, 8);
        fe(8); rt(3, 1060);
        run(1, 0, 3);

        // lw with three wait states on the data access
        init();
        wait_addr = 12'd8;
        wait_n = 3;
        put(0, ei(OP_LW, 0, 2, 16'd8));
        put(4, ej(26'd3));
        put(8, 32'hDEADBEEF);
        put(12, ei(OP_SW, 0, 2, 16'h104));
        put(16, ej(26'd265));
        fe(0); rdx(8); rt(8, 4);
        fe(4); rt(3, 12);
        fe(12); wr(12'h104, 32'hDEADBEEF); rt(4, 16);
        fe(16); rt(3, 1060);
        run(1, 0, 4);

        // beq taken (7==7) and not taken (7!=6)
        for (int t = 0; t < 2; t++) begin
            init();
            put(0, ej(26'd5));
            put(20, ei(OP_ADDI, 0, 1, 16'd7));
            put(24, ei(OP_ADDI, 0, 3, t == 0 ? 16'd7 : 16'd6));
            put(28, ej(26'd3));
            put(12, ei(OP_BEQ, 1, 3, 16'hFFFE));
            put(8, ej(26'd265));
            put(16, ej(26'd265));
            fe(0); rt(3, 20);
            fe(20); rt(4, 24);
            fe(24); rt(4, 28);
            fe(28); rt(3, 12);
            fe(12); rt(3, t == 0 ? 12'd8 : 12'd16);
            fe(t == 0 ? 12'd8 : 12'd16); rt(3, 1060);
            run(1, 0, 6);
        end

        // R-type ops, signed slt, $0 write ignored; results stored out
        init();
        put(0, ei(OP_ADDI, 0, 1, 16'd1));
        put(4, er(0, 1, 4, F_SUB));
        put(8, er(4, 1, 5, F_SLT));
        put(12, er(1, 1, 0, F_ADD));
        put(16, er(4, 1, 6, F_AND));
        put(20, er(1, 4, 7, F_OR));
        put(24, er(1, 4, 8, F_SLT));
        regs = '{5'd4, 5'd5, 5'd0, 5'd6, 5'd7, 5'd8};
        vals = '{32'hFFFFFFFF, 32'd1, 32'd0, 32'd1, 32'hFFFFFFFF, 32'd0};
        fe(0); rt(4, 4);
        for (int k = 1; k < 7; k++) begin
            fe(12'(4 * k)); rt(4, 12'(4 * k + 4));
        end
        for (int k = 0; k < 6; k++) begin
            put(12'(28 + 4 * k), ei(OP_SW, 0, regs[k], 16'(16'h110 + 4 * k)));
            fe(12'(28 + 4 * k)); wr(12'(12'h110 + 4 * k), vals[k]); rt(4, 12'(32 + 4 * k));
        end
        put(52, ej(26'd265));
        fe(52); rt(3, 1060);
        run(1, 0, 14);

        // misaligned lw: trap before any data request
        init();
        put(0, ei(OP_LW, 0, 2, 16'd6));
        fe(0);
        run(0, 1, 0);

        // undefined opcode 0x3F
        init();
        put(0, 32'hFC000000);
        fe(0);
        run(0, 1, 0);

        // R-type with undefined funct 0x21
        init();
        put(0, er(1, 2, 3, 6'h21));
        fe(0);
        run(0, 1, 0);

        // counted loop that falls into HALT_PC
        init();
        put(0, ej(26'd260));
        put(1040, ei(OP_ADDI, 0, 2, 16'd2));
        put(1044, ei(OP_BEQ, 2, 0, 16'd3));
        put(1048, ei(OP_ADDI, 2, 2, 16'hFFFF));
        put(1052, ej(26'd261));
        fe(0); rt(3, 1040);
        fe(1040); rt(4, 1044);
        for (int k = 0; k < 2; k++) begin
            fe(1044); rt(3, 1048);
            fe(1048); rt(4, 1052);
            fe(1052); rt(3, 1044);
        end
        fe(1044); rt(3, 1060);
        run(1, 0, 9);

        // PC wraps from 4092 to 0
        init();
        put(0, ei(OP_BEQ, 1, 0, 16'd1));
        put(4, ej(26'd265));
        put(8, ej(26'd1023));
        put(4092, ei(OP_ADDI, 0, 1, 16'd9));
        fe(0); rt(3, 8);
        fe(8); rt(3, 4092);
        fe(4092); rt(4, 0);
        fe(0); rt(3, 4);
        fe(4); rt(3, 1060);
        run(1, 0, 5);

        // reset asserted while a lw is stalled
        init();
        wait_addr = 12'd8;
        wait_n = 20;
        put(0, ei(OP_LW, 0, 2, 16'd8));
        put(8, 32'h12345678);
        fe(0); rdx(8);
        @(posedge clk);
        #1 rst_n = 1;
        begin
            bit seen = 0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                seen = mem_req && mem_addr == 12'd8;
            end
            check("lw_stall_seen", 32'(seen), 32'd1);
        end
        repeat (2) @(negedge clk);
        rst_n = 0;
        #1;
        check("midrst_mem_req", 32'(mem_req), 0);
        check("midrst_pc", 32'(pc), 0);
        check("midrst_retire", 32'(retire), 0);
        check("midrst_inflight_left", 32'(exp_acc.size()), 32'd1);

        // after the aborted lw, $2 must still be zero
        init();
        put(0, ei(OP_SW, 0, 2, 16'h120));
        put(4, ej(26'd265));
        fe(0); wr(12'h120, 32'd0); rt(4, 4);
        fe(4); rt(3, 1060);
        run(1, 0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
